// File: rtl/tlb_unit_pkg.sv
// Shared types and field positions for the joint TLB and its cp0 interface.
package tlb_unit_pkg;

  localparam logic [1:0] OP_TLBWI = 2'd0;
  localparam logic [1:0] OP_TLBR  = 2'd1;
  localparam logic [1:0] OP_TLBP  = 2'd2;

  localparam int VPN2_W = 19;
  localparam int ASID_W = 8;
  localparam int PFN_W  = 20;

  localparam int HI_VPN2_MSB = 31;
  localparam int HI_VPN2_LSB = 13;
  localparam int HI_ASID_MSB = 7;
  localparam int HI_ASID_LSB = 0;

  localparam int LO_PFN_MSB = 25;
  localparam int LO_PFN_LSB = 6;
  localparam int LO_C_MSB   = 5;
  localparam int LO_C_LSB   = 3;
  localparam int LO_D       = 2;
  localparam int LO_V       = 1;
  localparam int LO_G       = 0;

  // vaddr[31:30] of kseg0/kseg1, which bypass the TLB
  localparam logic [1:0] SEG_UNMAPPED = 2'b10;

  typedef struct packed {
    logic [VPN2_W-1:0] vpn2;
    logic [ASID_W-1:0] asid;
    logic              g;
    logic [PFN_W-1:0]  pfn0;
    logic [2:0]        c0;
    logic              d0;
    logic              v0;
    logic [PFN_W-1:0]  pfn1;
    logic [2:0]        c1;
    logic              d1;
    logic              v1;
  } tlb_entry_t;

  typedef enum logic {S_IDLE, S_RESP} tlb_state_t;

endpackage

// File: rtl/tlb_match.sv
// Parallel VPN2/ASID compare across all entries with lowest-index priority.
module tlb_match
  import tlb_unit_pkg::*;
#(
  parameter int TLB_NUM = 16,
  parameter int IDX_W   = 4
) (
  input  logic [TLB_NUM-1:0][VPN2_W-1:0] vpn2_arr,
  input  logic [TLB_NUM-1:0][ASID_W-1:0] asid_arr,
  input  logic [TLB_NUM-1:0]             g_arr,
  input  logic [VPN2_W-1:0]              vpn2,
  input  logic [ASID_W-1:0]              asid,
  output logic                           hit,
  output logic [IDX_W-1:0]               idx
);

  logic [TLB_NUM-1:0] hit_vec;

  for (genvar e = 0; e < TLB_NUM; e++) begin : g_cmp
    assign hit_vec[e] = (vpn2_arr[e] == vpn2) && (g_arr[e] || (asid_arr[e] == asid));
  end

  // Scan downward so the lowest matching index is the one left standing.
  always_comb begin
    hit = |hit_vec;
    idx = '0;
    for (int e = TLB_NUM - 1; e >= 0; e--) begin
      if (hit_vec[e]) idx = IDX_W'(e);
    end
  end

endmodule

// File: rtl/tlb_unit.sv
// Joint TLB: cp0 TLBWI/TLBR/TLBP sequencer plus two registered translation ports.
module tlb_unit
  import tlb_unit_pkg::*;
#(
  parameter int TLB_NUM = 16,
  parameter int IDX_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [1:0]  op_type,
  output logic        op_ready,
  input  logic [31:0] cp0_index,
  input  logic [31:0] cp0_entryhi,
  input  logic [31:0] cp0_entrylo0,
  input  logic [31:0] cp0_entrylo1,
  output logic        w_cp0_tlbp_ena,
  output logic        w_cp0_tlbr_ena,
  output logic [31:0] w_cp0_Index,
  output logic [31:0] w_cp0_EntryHi,
  output logic [31:0] w_cp0_EntryLo0,
  output logic [31:0] w_cp0_EntryLo1,
  input  logic        i_req,
  input  logic [31:0] i_vaddr,
  output logic        i_resp,
  output logic [31:0] i_paddr,
  output logic        i_refill,
  output logic        i_invalid,
  input  logic        d_req,
  input  logic [31:0] d_vaddr,
  input  logic        d_store,
  output logic        d_resp,
  output logic [31:0] d_paddr,
  output logic        d_refill,
  output logic        d_invalid,
  output logic        d_modified
);

  tlb_entry_t [TLB_NUM-1:0]          tlb;
  logic [TLB_NUM-1:0][VPN2_W-1:0]    vpn2_arr;
  logic [TLB_NUM-1:0][ASID_W-1:0]    asid_arr;
  logic [TLB_NUM-1:0]                g_arr;

  tlb_state_t        state, state_nxt;
  logic              accept;
  logic [1:0]        op_q;
  logic [VPN2_W-1:0] p_vpn2_q;
  logic [ASID_W-1:0] p_asid_q;
  tlb_entry_t        rd_q;
  tlb_entry_t        wr_ent;
  logic              p_hit;
  logic [IDX_W-1:0]  p_idx;
  logic [IDX_W-1:0]  op_idx;

  logic [1:0]        x_req, x_store;
  logic [1:0][31:0]  x_vaddr;

  assign op_idx  = cp0_index[IDX_W-1:0];
  assign x_req   = {d_req, i_req};
  assign x_store = {d_store, 1'b0};
  assign x_vaddr = {d_vaddr, i_vaddr};

  for (genvar e = 0; e < TLB_NUM; e++) begin : g_view
    assign vpn2_arr[e] = tlb[e].vpn2;
    assign asid_arr[e] = tlb[e].asid;
    assign g_arr[e]    = tlb[e].g;
  end

  always_comb begin
    wr_ent      = '0;
    wr_ent.vpn2 = cp0_entryhi[HI_VPN2_MSB:HI_VPN2_LSB];
    wr_ent.asid = cp0_entryhi[HI_ASID_MSB:HI_ASID_LSB];
    wr_ent.g    = cp0_entrylo0[LO_G] & cp0_entrylo1[LO_G];
    wr_ent.pfn0 = cp0_entrylo0[LO_PFN_MSB:LO_PFN_LSB];
    wr_ent.c0   = cp0_entrylo0[LO_C_MSB:LO_C_LSB];
    wr_ent.d0   = cp0_entrylo0[LO_D];
    wr_ent.v0   = cp0_entrylo0[LO_V];
    wr_ent.pfn1 = cp0_entrylo1[LO_PFN_MSB:LO_PFN_LSB];
    wr_ent.c1   = cp0_entrylo1[LO_C_MSB:LO_C_LSB];
    wr_ent.d1   = cp0_entrylo1[LO_D];
    wr_ent.v1   = cp0_entrylo1[LO_V];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    op_ready  = 1'b0;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          accept    = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tlb <= '0;
    end else if (accept && op_type == OP_TLBWI) begin
      tlb[op_idx] <= wr_ent;
    end
  end

  // TLBR source is sampled here, so RESP works from a stable copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      p_vpn2_q <= '0;
      p_asid_q <= '0;
      rd_q     <= '0;
    end else if (accept) begin
      op_q     <= op_type;
      p_vpn2_q <= cp0_entryhi[HI_VPN2_MSB:HI_VPN2_LSB];
      p_asid_q <= cp0_entryhi[HI_ASID_MSB:HI_ASID_LSB];
      rd_q     <= tlb[op_idx];
    end
  end

  tlb_match #(.TLB_NUM(TLB_NUM), .IDX_W(IDX_W)) u_probe (
    .vpn2_arr (vpn2_arr),
    .asid_arr (asid_arr),
    .g_arr    (g_arr),
    .vpn2     (p_vpn2_q),
    .asid     (p_asid_q),
    .hit      (p_hit),
    .idx      (p_idx)
  );

  // Results are resolved during RESP and registered on its closing edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_cp0_tlbp_ena <= 1'b0;
      w_cp0_tlbr_ena <= 1'b0;
      w_cp0_Index    <= '0;
      w_cp0_EntryHi  <= '0;
      w_cp0_EntryLo0 <= '0;
      w_cp0_EntryLo1 <= '0;
    end else begin
      w_cp0_tlbp_ena <= (state == S_RESP) && (op_q == OP_TLBP);
      w_cp0_tlbr_ena <= (state == S_RESP) && (op_q == OP_TLBR);
      if (state == S_RESP && op_q == OP_TLBP)
        w_cp0_Index <= p_hit ? {{(32-IDX_W){1'b0}}, p_idx} : 32'h8000_0000;
      if (state == S_RESP && op_q == OP_TLBR) begin
        w_cp0_EntryHi  <= {rd_q.vpn2, 5'b0, rd_q.asid};
        w_cp0_EntryLo0 <= {6'b0, rd_q.pfn0, rd_q.c0, rd_q.d0, rd_q.v0, rd_q.g};
        w_cp0_EntryLo1 <= {6'b0, rd_q.pfn1, rd_q.c1, rd_q.d1, rd_q.v1, rd_q.g};
      end
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic             hit, odd, unmapped, v, d;
    logic [IDX_W-1:0] idx;
    logic [PFN_W-1:0] pfn;
    logic             resp, refill, invalid, mod;
    logic [31:0]      paddr;

    tlb_match #(.TLB_NUM(TLB_NUM), .IDX_W(IDX_W)) u_match (
      .vpn2_arr (vpn2_arr),
      .asid_arr (asid_arr),
      .g_arr    (g_arr),
      .vpn2     (x_vaddr[p][HI_VPN2_MSB:HI_VPN2_LSB]),
      .asid     (cp0_entryhi[HI_ASID_MSB:HI_ASID_LSB]),
      .hit      (hit),
      .idx      (idx)
    );

    always_comb begin
      odd      = x_vaddr[p][12];
      pfn      = odd ? tlb[idx].pfn1 : tlb[idx].pfn0;
      v        = odd ? tlb[idx].v1   : tlb[idx].v0;
      d        = odd ? tlb[idx].d1   : tlb[idx].d0;
      unmapped = (x_vaddr[p][31:30] == SEG_UNMAPPED);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        resp    <= 1'b0;
        paddr   <= '0;
        refill  <= 1'b0;
        invalid <= 1'b0;
        mod     <= 1'b0;
      end else begin
        resp    <= x_req[p];
        paddr   <= '0;
        refill  <= 1'b0;
        invalid <= 1'b0;
        mod     <= 1'b0;
        if (x_req[p]) begin
          if (unmapped) begin
            paddr <= {3'b0, x_vaddr[p][28:0]};
          end else if (!hit) begin
            refill <= 1'b1;
          end else begin
            paddr   <= {pfn, x_vaddr[p][11:0]};
            invalid <= !v;
            mod     <= v && x_store[p] && !d;
          end
        end
      end
    end
  end

  assign i_resp     = g_port[0].resp;
  assign i_paddr    = g_port[0].paddr;
  assign i_refill   = g_port[0].refill;
  assign i_invalid  = g_port[0].invalid;
  assign d_resp     = g_port[1].resp;
  assign d_paddr    = g_port[1].paddr;
  assign d_refill   = g_port[1].refill;
  assign d_invalid  = g_port[1].invalid;
  assign d_modified = g_port[1].mod;

  logic unused_bits;
  assign unused_bits = ^{cp0_index[31:IDX_W], cp0_entryhi[12:8], cp0_entrylo0[31:26],
                         cp0_entrylo1[31:26], g_port[0].mod};

endmodule

// File: tb/tb_tlb_unit.sv
// Randomized scoreboard bench for tlb_unit against an array-of-words reference model.
module tb_tlb_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic [1:0]  op_type = 2'd0;
  logic        op_ready;
  logic [31:0] cp0_index = '0, cp0_entryhi = '0, cp0_entrylo0 = '0, cp0_entrylo1 = '0;
  logic        w_cp0_tlbp_ena, w_cp0_tlbr_ena;
  logic [31:0] w_cp0_Index, w_cp0_EntryHi, w_cp0_EntryLo0, w_cp0_EntryLo1;
  logic        i_req = 1'b0;
  logic [31:0] i_vaddr = '0;
  logic        i_resp, i_refill, i_invalid;
  logic [31:0] i_paddr;
  logic        d_req = 1'b0, d_store = 1'b0;
  logic [31:0] d_vaddr = '0;
  logic        d_resp, d_refill, d_invalid, d_modified;
  logic [31:0] d_paddr;

  tlb_unit dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_type(op_type), .op_ready(op_ready),
    .cp0_index(cp0_index), .cp0_entryhi(cp0_entryhi),
    .cp0_entrylo0(cp0_entrylo0), .cp0_entrylo1(cp0_entrylo1),
    .w_cp0_tlbp_ena(w_cp0_tlbp_ena), .w_cp0_tlbr_ena(w_cp0_tlbr_ena),
    .w_cp0_Index(w_cp0_Index), .w_cp0_EntryHi(w_cp0_EntryHi),
    .w_cp0_EntryLo0(w_cp0_EntryLo0), .w_cp0_EntryLo1(w_cp0_EntryLo1),
    .i_req(i_req), .i_vaddr(i_vaddr), .i_resp(i_resp), .i_paddr(i_paddr),
    .i_refill(i_refill), .i_invalid(i_invalid),
    .d_req(d_req), .d_vaddr(d_vaddr), .d_store(d_store), .d_resp(d_resp),
    .d_paddr(d_paddr), .d_refill(d_refill), .d_invalid(d_invalid), .d_modified(d_modified)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: raw cp0 words per entry, unused bits masked off.
  logic [31:0] m_hi [16];
  logic [31:0] m_lo [16][2];
  logic        m_g  [16];

  typedef struct { int cyc; logic [31:0] paddr; logic refill, invalid, modified; } xp_t;
  typedef struct { int cyc; bit is_p; logic [31:0] index, hi, lo0, lo1; } opx_t;

  xp_t  iq[$], dq[$];
  opx_t oq[$];
  int   checks = 0, errors = 0;
  bit   busy = 1'b0, drop = 1'b0;
  logic [31:0] last_index = '0, last_hi = '0, last_lo0 = '0, last_lo1 = '0;
  logic [18:0] pool [4] = '{19'h00201, 19'h00402, 19'h7ffff, 19'h00123};

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_hi[i] = '0; m_lo[i][0] = '0; m_lo[i][1] = '0; m_g[i] = 1'b0;
    end
  endfunction

  function automatic int model_find(logic [18:0] vpn2, logic [7:0] asid);
    for (int i = 0; i < 16; i++)
      if (m_hi[i][31:13] == vpn2 && (m_g[i] || m_hi[i][7:0] == asid)) return i;
    return -1;
  endfunction

  function automatic void model_xlate(logic [31:0] va, logic [7:0] asid, logic st, output xp_t e);
    int r;
    logic [31:0] lo;
    e = '{cyc: 0, paddr: 32'h0, refill: 1'b0, invalid: 1'b0, modified: 1'b0};
    if (va[31:30] == 2'b10) begin
      e.paddr = va & 32'h1FFF_FFFF;
    end else begin
      r = model_find(va[31:13], asid);
      if (r < 0) e.refill = 1'b1;
      else begin
        lo = m_lo[r][va[12]];
        e.paddr    = {lo[25:6], va[11:0]};
        e.invalid  = !lo[1];
        e.modified = lo[1] && st && !lo[2];
      end
    end
  endfunction

  // Predicts everything launched at the coming edge, then drives past it.
  task automatic tick();
    xp_t  e;
    opx_t o;
    int   idx, r;
    chk("op_ready", 32'(op_ready), 32'(!busy));
    if (i_req) begin
      model_xlate(i_vaddr, cp0_entryhi[7:0], 1'b0, e); e.cyc = cyc + 1; iq.push_back(e);
    end
    if (d_req) begin
      model_xlate(d_vaddr, cp0_entryhi[7:0], d_store, e); e.cyc = cyc + 1; dq.push_back(e);
    end
    if (op_valid && !busy) begin
      idx = int'(cp0_index[3:0]);
      o = '{cyc: cyc + 2, is_p: 1'b0, index: 32'h0, hi: 32'h0, lo0: 32'h0, lo1: 32'h0};
      case (op_type)
        2'd0: begin
          m_hi[idx]    = cp0_entryhi & 32'hFFFF_E0FF;
          m_lo[idx][0] = cp0_entrylo0 & 32'h03FF_FFFE;
          m_lo[idx][1] = cp0_entrylo1 & 32'h03FF_FFFE;
          m_g[idx]     = cp0_entrylo0[0] & cp0_entrylo1[0];
        end
        2'd1: begin
          o.hi  = m_hi[idx];
          o.lo0 = m_lo[idx][0] | 32'(m_g[idx]);
          o.lo1 = m_lo[idx][1] | 32'(m_g[idx]);
          if (!drop) oq.push_back(o);
        end
        2'd2: begin
          o.is_p  = 1'b1;
          r       = model_find(cp0_entryhi[31:13], cp0_entryhi[7:0]);
          o.index = (r < 0) ? 32'h8000_0000 : 32'(r);
          if (!drop) oq.push_back(o);
        end
        default: ;
      endcase
    end
    busy = op_valid && !busy;
    @(negedge clk);
    op_valid = 1'b0; i_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic do_op(logic [1:0] t, logic [31:0] idx, logic [31:0] hi, logic [31:0] lo0, logic [31:0] lo1);
    op_type = t; cp0_index = idx; cp0_entryhi = hi; cp0_entrylo0 = lo0; cp0_entrylo1 = lo1;
    op_valid = 1'b1;
    tick(); tick(); tick();
  endtask

  function automatic logic [31:0] rand_hi();
    return {pool[$urandom_range(0, 3)], 5'($urandom), 8'($urandom_range(1, 3))};
  endfunction

  function automatic logic [31:0] rand_va();
    if ($urandom_range(0, 3) != 0) return {pool[$urandom_range(0, 3)], 13'($urandom)};
    return $urandom;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a response.
  initial begin
    opx_t o;
    xp_t  e;
    forever begin
      @(negedge clk);
      while (oq.size() > 0 && oq[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL wb_missing: expected pulse at cycle %0d, none by %0d", oq[0].cyc, cyc);
        void'(oq.pop_front());
      end
      while (iq.size() > 0 && iq[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL i_missing: expected resp at cycle %0d, none by %0d", iq[0].cyc, cyc);
        void'(iq.pop_front());
      end
      while (dq.size() > 0 && dq[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL d_missing: expected resp at cycle %0d, none by %0d", dq[0].cyc, cyc);
        void'(dq.pop_front());
      end

      if (w_cp0_tlbp_ena || w_cp0_tlbr_ena) begin
        if (oq.size() == 0) begin
          checks++; errors++;
          $display("FAIL wb_unexpected: pulse p=%0b r=%0b with nothing expected", w_cp0_tlbp_ena, w_cp0_tlbr_ena);
        end else begin
          o = oq.pop_front();
          chk("wb_cycle", 32'(cyc), 32'(o.cyc));
          chk("wb_kind", {30'b0, w_cp0_tlbp_ena, w_cp0_tlbr_ena}, {30'b0, o.is_p, !o.is_p});
          if (o.is_p) begin
            chk("tlbp_index", w_cp0_Index, o.index);
            last_index = o.index;
          end else begin
            chk("tlbr_hi", w_cp0_EntryHi, o.hi);
            chk("tlbr_lo0", w_cp0_EntryLo0, o.lo0);
            chk("tlbr_lo1", w_cp0_EntryLo1, o.lo1);
            last_hi = o.hi; last_lo0 = o.lo0; last_lo1 = o.lo1;
          end
        end
      end
      if (!w_cp0_tlbp_ena) chk("index_hold", w_cp0_Index, last_index);
      if (!w_cp0_tlbr_ena) begin
        chk("hi_hold", w_cp0_EntryHi, last_hi);
        chk("lo_hold", w_cp0_EntryLo0 ^ w_cp0_EntryLo1, last_lo0 ^ last_lo1);
      end

      if (i_resp) begin
        if (iq.size() == 0) begin
          checks++; errors++; $display("FAIL i_unexpected: resp with nothing expected");
        end else begin
          e = iq.pop_front();
          chk("i_cycle", 32'(cyc), 32'(e.cyc));
          chk("i_paddr", i_paddr, e.paddr);
          chk("i_flags", {30'b0, i_refill, i_invalid}, {30'b0, e.refill, e.invalid});
        end
      end else begin
        chk("i_idle", i_paddr | {30'b0, i_refill, i_invalid}, 32'h0);
      end

      if (d_resp) begin
        if (dq.size() == 0) begin
          checks++; errors++; $display("FAIL d_unexpected: resp with nothing expected");
        end else begin
          e = dq.pop_front();
          chk("d_cycle", 32'(cyc), 32'(e.cyc));
          chk("d_paddr", d_paddr, e.paddr);
          chk("d_flags", {29'b0, d_refill, d_invalid, d_modified},
                         {29'b0, e.refill, e.invalid, e.modified});
        end
      end else begin
        chk("d_idle", d_paddr | {29'b0, d_refill, d_invalid, d_modified}, 32'h0);
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_op_ready", 32'(op_ready), 32'h1);
    chk("rst_pulses", {30'b0, w_cp0_tlbp_ena, w_cp0_tlbr_ena}, 32'h0);
    chk("rst_index", w_cp0_Index, 32'h0);
    chk("rst_resp", {30'b0, i_resp, d_resp}, 32'h0);

    // Empty TLB probe, then install/probe/read back entry 5.
    do_op(2'd2, 32'd0, 32'h0040_2001, 32'h0, 32'h0);
    do_op(2'd0, 32'd5, 32'h0040_2001, 32'h0000_1046, 32'h0000_1087);
    do_op(2'd2, 32'd0, 32'h0040_2001, 32'h0, 32'h0);
    do_op(2'd1, 32'd5, 32'h0040_2001, 32'h0, 32'h0);

    // Store through the odd half: dirty, then clean (modified).
    d_req = 1'b1; d_vaddr = 32'h0040_3ABC; d_store = 1'b1; tick(); tick();
    do_op(2'd0, 32'd5, 32'h0040_2001, 32'h0000_1046, 32'h0000_1083);
    d_req = 1'b1; d_vaddr = 32'h0040_3ABC; d_store = 1'b1; tick(); tick();

    // Unmapped kseg1 fetch and a refill miss.
    i_req = 1'b1; i_vaddr = 32'hBFC0_0000; tick();
    i_req = 1'b1; i_vaddr = 32'h1234_5000; tick(); tick();

    // Duplicate entries at 3 and 9; even half invalid.
    do_op(2'd0, 32'd9, 32'h0080_4002, 32'h0000_2044, 32'h0000_2087);
    do_op(2'd0, 32'd3, 32'h0080_4002, 32'h0000_2044, 32'h0000_2087);
    do_op(2'd2, 32'd0, 32'h0080_4002, 32'h0, 32'h0);
    d_req = 1'b1; d_vaddr = 32'h0080_4123; d_store = 1'b0; tick(); tick();

    // Reset during RESP of a TLBP: pulse must never appear.
    op_type = 2'd2; cp0_entryhi = 32'h0040_2001; op_valid = 1'b1; drop = 1'b1;
    tick();
    drop = 1'b0;
    #2;
    rst = 1'b1; model_reset(); busy = 1'b0;
    last_index = '0; last_hi = '0; last_lo0 = '0; last_lo1 = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    tick();
    do_op(2'd2, 32'd0, 32'h0040_2001, 32'h0, 32'h0);

    // Fill every entry, then free-running random traffic.
    for (int i = 0; i < 16; i++)
      do_op(2'd0, 32'(i), rand_hi(), $urandom, $urandom);
    for (int n = 0; n < 800; n++) begin
      cp0_entryhi  = rand_hi();
      cp0_index    = $urandom;
      cp0_entrylo0 = $urandom;
      cp0_entrylo1 = $urandom;
      op_valid     = ($urandom_range(0, 2) == 0);
      op_type      = 2'($urandom_range(0, 3));
      i_req        = ($urandom_range(0, 3) != 0);
      i_vaddr      = rand_va();
      d_req        = ($urandom_range(0, 3) != 0);
      d_vaddr      = rand_va();
      d_store      = 1'($urandom_range(0, 1));
      tick();
    end
    repeat (4) tick();
    chk("wb_left", 32'(oq.size()), 32'h0);
    chk("i_left", 32'(iq.size()), 32'h0);
    chk("d_left", 32'(dq.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
